// File: rtl/axil_lite_client_adapter.sv
// AXI4-Lite slave that turns each read or write into one command on a valid/ready client port.
// Optional: define AXIL_ADAPTOR_STRB_ERR_EN to answer unsupported wstrb patterns with SLVERR.

module axil_lite_client_adapter #(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32,
  localparam int lanes_lp         = axil_data_width_p / 8,
  localparam int lane_bits_lp     = $clog2(lanes_lp),
  localparam int size_width_lp    = $clog2(lane_bits_lp + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  output logic                         cmd_v_o,
  input  logic                         cmd_ready_and_i,
  output logic [axil_addr_width_p-1:0] cmd_addr_o,
  output logic                         cmd_wr_en_o,
  output logic [size_width_lp-1:0]     cmd_data_size_o,
  output logic [axil_data_width_p-1:0] cmd_wdata_o,

  input  logic                         resp_v_i,
  output logic                         resp_ready_and_o,
  input  logic [axil_data_width_p-1:0] resp_rdata_i,

  input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                   s_axil_awprot_i,
  input  logic                         s_axil_awvalid_i,
  output logic                         s_axil_awready_o,
  input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
  input  logic [lanes_lp-1:0]          s_axil_wstrb_i,
  input  logic                         s_axil_wvalid_i,
  output logic                         s_axil_wready_o,
  output logic [1:0]                   s_axil_bresp_o,
  output logic                         s_axil_bvalid_o,
  input  logic                         s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                   s_axil_arprot_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [axil_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i
);

  localparam logic [size_width_lp-1:0] full_size_lp = size_width_lp'(lane_bits_lp);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WRESP = 3'd2,
    RRESP = 3'd3
`ifdef AXIL_ADAPTOR_STRB_ERR_EN
    , BERR = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic                     ok;
    logic [size_width_lp-1:0] size;
    logic [lane_bits_lp-1:0]  lo;
  } strb_dec_t;

  // Supported patterns: all lanes, or 1/2/4 contiguous lanes aligned to their own size.
  function automatic strb_dec_t decode_strb(input logic [lanes_lp-1:0] strb);
    strb_dec_t            d;
    logic [lanes_lp-1:0]  ones_v;
    d      = '0;
    ones_v = {lanes_lp{1'b1}};
    if (strb == ones_v) begin
      d.ok   = 1'b1;
      d.size = full_size_lp;
    end else begin
      for (int s = 0; s < lane_bits_lp; s++) begin
        for (int l = 0; l < lanes_lp; l++) begin
          if (((l & ((1 << s) - 1)) == 0) &&
              (strb == ((ones_v >> (lanes_lp - (1 << s))) << l))) begin
            d.ok   = 1'b1;
            d.size = size_width_lp'(s);
            d.lo   = lane_bits_lp'(l);
          end
        end
      end
    end
    return d;
  endfunction

  state_e                         state_r, state_n_s;
  logic [axil_addr_width_p-1:0]   addr_r, waddr_s;
  logic [axil_data_width_p-1:0]   wdata_r, wdata_s;
  logic [size_width_lp-1:0]       size_r, wsize_s;
  logic                           wr_r;
  logic                           cap_wr_s, cap_rd_s;
  strb_dec_t                      dec_s;
  logic                           unused_s;

  assign unused_s = ^{s_axil_awprot_i, s_axil_arprot_i};

  // Lane-align the incoming write before it is captured.
  always_comb begin
    dec_s = decode_strb(s_axil_wstrb_i);
    if (dec_s.ok) begin
      waddr_s = {s_axil_awaddr_i[axil_addr_width_p-1:lane_bits_lp], dec_s.lo};
      wdata_s = s_axil_wdata_i >> {dec_s.lo, 3'b000};
      wsize_s = dec_s.size;
    end else begin
      waddr_s = s_axil_awaddr_i;
      wdata_s = s_axil_wdata_i;
      wsize_s = full_size_lp;
    end
  end

  // State register and captured command fields.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      addr_r  <= {axil_addr_width_p{1'b0}};
      wdata_r <= {axil_data_width_p{1'b0}};
      size_r  <= {size_width_lp{1'b0}};
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (cap_wr_s) begin
        addr_r  <= waddr_s;
        wdata_r <= wdata_s;
        size_r  <= wsize_s;
        wr_r    <= 1'b1;
      end else if (cap_rd_s) begin
        addr_r  <= s_axil_araddr_i;
        wdata_r <= {axil_data_width_p{1'b0}};
        size_r  <= full_size_lp;
        wr_r    <= 1'b0;
      end else begin
        wr_r    <= wr_r;
      end
    end
  end

  // Next-state and handshake decode; responses pass straight through.
  always_comb begin
    state_n_s        = state_r;
    cap_wr_s         = 1'b0;
    cap_rd_s         = 1'b0;
    s_axil_awready_o = 1'b0;
    s_axil_wready_o  = 1'b0;
    s_axil_arready_o = 1'b0;
    s_axil_bvalid_o  = 1'b0;
    s_axil_bresp_o   = 2'b00;
    s_axil_rvalid_o  = 1'b0;
    s_axil_rdata_o   = {axil_data_width_p{1'b0}};
    s_axil_rresp_o   = 2'b00;
    resp_ready_and_o = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_axil_awvalid_i && s_axil_wvalid_i) begin
          s_axil_awready_o = 1'b1;
          s_axil_wready_o  = 1'b1;
          cap_wr_s         = 1'b1;
`ifdef AXIL_ADAPTOR_STRB_ERR_EN
          state_n_s        = dec_s.ok ? CMD : BERR;
`else
          state_n_s        = CMD;
`endif
        end else if (s_axil_arvalid_i) begin
          s_axil_arready_o = 1'b1;
          cap_rd_s         = 1'b1;
          state_n_s        = CMD;
        end else begin
          state_n_s        = IDLE;
        end
      end
      CMD: begin
        if (cmd_ready_and_i) begin
          state_n_s = wr_r ? WRESP : RRESP;
        end else begin
          state_n_s = CMD;
        end
      end
      WRESP: begin
        s_axil_bvalid_o  = resp_v_i;
        resp_ready_and_o = s_axil_bready_i;
        if (resp_v_i && s_axil_bready_i) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = WRESP;
        end
      end
      RRESP: begin
        s_axil_rvalid_o  = resp_v_i;
        s_axil_rdata_o   = resp_rdata_i;
        resp_ready_and_o = s_axil_rready_i;
        if (resp_v_i && s_axil_rready_i) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = RRESP;
        end
      end
`ifdef AXIL_ADAPTOR_STRB_ERR_EN
      BERR: begin
        s_axil_bvalid_o = 1'b1;
        s_axil_bresp_o  = 2'b10;
        if (s_axil_bready_i) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = BERR;
        end
      end
`endif
      default: state_n_s = IDLE;
    endcase
  end

  assign cmd_v_o         = (state_r == CMD);
  assign cmd_addr_o      = addr_r;
  assign cmd_wr_en_o     = wr_r;
  assign cmd_data_size_o = size_r;
  assign cmd_wdata_o     = wdata_r;

endmodule

// File: tb/tb_axil_lite_client_adapter.sv
// Scoreboard bench for axil_lite_client_adapter: randomized AXI-Lite traffic against a lane-arithmetic model.
// Honours AXIL_ADAPTOR_STRB_ERR_EN the same way as the design.

module tb_axil_lite_client_adapter;

  logic        clk_i = 1'b0, reset_n_i = 1'b0;
  logic        cmd_v_o, cmd_ready_and_i = 1'b0, cmd_wr_en_o;
  logic [31:0] cmd_addr_o, cmd_wdata_o;
  logic [1:0]  cmd_data_size_o;
  logic        resp_v_i = 1'b0, resp_ready_and_o;
  logic [31:0] resp_rdata_i = 32'd0;
  logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic [31:0] rdata;
  logic        rvalid, rready = 1'b0;

  axil_lite_client_adapter #(.axil_data_width_p(32), .axil_addr_width_p(32)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i), .cmd_addr_o(cmd_addr_o),
    .cmd_wr_en_o(cmd_wr_en_o), .cmd_data_size_o(cmd_data_size_o), .cmd_wdata_o(cmd_wdata_o),
    .resp_v_i(resp_v_i), .resp_ready_and_o(resp_ready_and_o), .resp_rdata_i(resp_rdata_i),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(3'b000), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready), .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb),
    .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready), .s_axil_bresp_o(bresp),
    .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready), .s_axil_araddr_i(araddr),
    .s_axil_arprot_i(3'b000), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t       exp_cmd_q[$];
  logic [1:0] exp_b_q[$];
  bit         exp_r_q[$];
  int         n_cmp = 0, n_err = 0;
  int         cmd_hs_cnt = 0, resp_hs_cnt = 0;
  int         ready_mode = 0;
  bit         busy = 1'b0, cmd_done = 1'b0, cur_wr = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Reference: a write strobe is usable when its set lanes form one power-of-two run aligned to its length.
  function automatic bit model_write(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb, output cmd_t c);
    int cnt, lo;
    bit ok;
    cnt = $countones(strb);
    lo  = 0;
    for (int i = 3; i >= 0; i--) if (strb[i]) lo = i;
    ok = (cnt != 0) && ((cnt & (cnt - 1)) == 0) && ((lo % cnt) == 0) &&
         ((int'(strb) >> lo) == ((1 << cnt) - 1));
    c.wr = 1'b1;
    if (ok) begin
      c.size  = 2'($clog2(cnt));
      c.addr  = {addr[31:2], 2'(lo)};
      c.wdata = data >> (8 * lo);
    end else begin
      c.size  = 2'd2;
      c.addr  = addr;
      c.wdata = data;
    end
    return ok;
  endfunction

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    bit   ok;
    ok = model_write(a, d, s, c);
`ifdef AXIL_ADAPTOR_STRB_ERR_EN
    if (!ok) begin
      exp_b_q.push_back(2'b10);
    end else begin
      exp_cmd_q.push_back(c);
      exp_b_q.push_back(2'b00);
    end
`else
    exp_cmd_q.push_back(c);
    exp_b_q.push_back(2'b00);
`endif
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
  endtask

  task automatic drive_read(input logic [31:0] a);
    cmd_t c;
    c.addr = a; c.wr = 1'b0; c.size = 2'd2; c.wdata = 32'd0;
    exp_cmd_q.push_back(c);
    exp_r_q.push_back(1'b1);
    araddr = a; arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (awvalid && wvalid && awready && wready) done = 1'b1;
    end
    if (!done) fail_now("aw_accept_timeout");
    @(posedge clk_i); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic wait_ar();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (arvalid && arready) done = 1'b1;
    end
    if (!done) fail_now("ar_accept_timeout");
    @(posedge clk_i); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk_i); #1;
      bready = ($urandom_range(0, 2) != 0);
      @(negedge clk_i);
      if (bvalid && bready) done = 1'b1;
    end
    if (!done) fail_now("b_timeout");
    @(posedge clk_i); #1;
    bready = 1'b0;
  endtask

  task automatic wait_r();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk_i); #1;
      rready = ($urandom_range(0, 2) != 0);
      @(negedge clk_i);
      if (rvalid && rready) done = 1'b1;
    end
    if (!done) fail_now("r_timeout");
    @(posedge clk_i); #1;
    rready = 1'b0;
  endtask

  // Client model: random command back-pressure, one response per accepted command.
  initial begin : client
    int seen_cmd = 0, seen_resp = 0, delay = 0;
    bit pending  = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (!reset_n_i) begin
        pending = 1'b0; resp_v_i = 1'b0;
        seen_cmd = cmd_hs_cnt; seen_resp = resp_hs_cnt;
      end else begin
        if (resp_hs_cnt != seen_resp) begin seen_resp = resp_hs_cnt; resp_v_i = 1'b0; end
        if (cmd_hs_cnt != seen_cmd) begin
          seen_cmd = cmd_hs_cnt; pending = 1'b1; delay = $urandom_range(0, 2);
        end
        if (pending) begin
          if (delay == 0) begin
            resp_v_i = 1'b1; resp_rdata_i = $urandom; pending = 1'b0;
          end else begin
            delay--;
          end
        end
      end
      case (ready_mode)
        1:       cmd_ready_and_i = 1'b0;
        2:       cmd_ready_and_i = 1'b1;
        default: cmd_ready_and_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: per-cycle protocol expectations plus scoreboard pops on every handshake.
  initial begin : monitor
    cmd_t e;
    logic exp_awr, exp_arr;
    logic [1:0] eb;
    bit   er;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        busy = 1'b0; cmd_done = 1'b0;
        exp_cmd_q.delete(); exp_b_q.delete(); exp_r_q.delete();
      end else begin
        exp_awr = !busy && awvalid && wvalid;
        exp_arr = !busy && arvalid && !(awvalid && wvalid);
        check("awready", awready, exp_awr);
        check("wready", wready, exp_awr);
        check("arready", arready, exp_arr);
        check("resp_ready", resp_ready_and_o, cmd_done ? (cur_wr ? bready : rready) : 1'b0);
        check("cmd_v_outside_cmd", cmd_v_o && !(busy && !cmd_done), 1'b0);
        if (!busy) begin
          check("bvalid_idle", bvalid, 1'b0);
          check("rvalid_idle", rvalid, 1'b0);
        end else if (cmd_done) begin
          check("bvalid_follow", bvalid, cur_wr ? resp_v_i : 1'b0);
          check("rvalid_follow", rvalid, cur_wr ? 1'b0 : resp_v_i);
        end
        if (cmd_v_o && cmd_ready_and_i) begin
          cmd_hs_cnt++;
          if (exp_cmd_q.size() == 0) begin
            fail_now("cmd_unexpected");
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_addr", cmd_addr_o, e.addr);
            check("cmd_wr_en", cmd_wr_en_o, e.wr);
            check("cmd_size", cmd_data_size_o, e.size);
            if (e.wr) check("cmd_wdata", cmd_wdata_o, e.wdata);
            cmd_done = 1'b1; cur_wr = e.wr;
          end
        end
        if (resp_v_i && resp_ready_and_o) resp_hs_cnt++;
        if (bvalid && bready) begin
          if (exp_b_q.size() == 0) begin
            fail_now("b_unexpected");
          end else begin
            eb = exp_b_q.pop_front();
            check("bresp", bresp, eb);
          end
          busy = 1'b0; cmd_done = 1'b0;
        end
        if (rvalid && rready) begin
          if (exp_r_q.size() == 0) begin
            fail_now("r_unexpected");
          end else begin
            er = exp_r_q.pop_front();
            check("rdata", rdata, resp_rdata_i);
            check("rresp", rresp, 2'b00);
          end
          busy = 1'b0; cmd_done = 1'b0;
        end
        if ((awvalid && wvalid && awready && wready) || (arvalid && arready)) busy = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #2;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_cmd_v", cmd_v_o, 1'b0);
    check("rst_cmd_addr", cmd_addr_o, 32'd0);
    check("rst_cmd_wr_en", cmd_wr_en_o, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_resp_ready", resp_ready_and_o, 1'b0);

    // Simultaneous write and read: write first, read after B.
    ready_mode = 2;
    @(posedge clk_i); #1;
    drive_write(32'h0000_0010, 32'h0102_0304, 4'hF);
    drive_read(32'h0000_0020);
    wait_aw();
    @(negedge clk_i);
    check("prio_cmd_v", cmd_v_o, 1'b1);
    check("prio_cmd_wr", cmd_wr_en_o, 1'b1);
    wait_b();
    wait_ar();
    wait_r();

    // Single-byte lane 2 write.
    @(posedge clk_i); #1;
    drive_write(32'h0000_0100, 32'hAABB_CCDD, 4'b0100);
    wait_aw();
    wait_b();

    // Read with three stalled command cycles.
    ready_mode = 1;
    @(posedge clk_i); #1;
    drive_read(32'h0000_0044);
    wait_ar();
    repeat (3) begin
      @(negedge clk_i);
      check("stall_cmd_v", cmd_v_o, 1'b1);
      check("stall_size", cmd_data_size_o, 2'd2);
    end
    ready_mode = 2;
    wait_r();

    // Unsupported strobe.
    ready_mode = 0;
    @(posedge clk_i); #1;
    drive_write(32'h0000_0080, 32'h1122_3344, 4'b0101);
    wait_aw();
    wait_b();

    // Reset while the command is stalled.
    ready_mode = 1;
    @(posedge clk_i); #1;
    drive_write(32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
    wait_aw();
    @(negedge clk_i);
    check("pre_reset_cmd_v", cmd_v_o, 1'b1);
    #2 reset_n_i = 1'b0;
    #1 check("async_reset_cmd_v", cmd_v_o, 1'b0);
    repeat (2) @(negedge clk_i);
    #2 reset_n_i = 1'b1;
    ready_mode = 0;
    @(negedge clk_i);
    check("post_reset_cmd_v", cmd_v_o, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      @(posedge clk_i); #1;
      if ($urandom_range(0, 1) == 1) begin
        drive_write({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        wait_aw();
        wait_b();
      end else begin
        drive_read($urandom);
        wait_ar();
        wait_r();
      end
    end

    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b_q.size()), 64'd0);
    check("r_queue_drained", 64'(exp_r_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
